mmio_router: RTL and testbench

Parametrised memory-mapped I/O router between the core data port and the chip's peripherals. It decodes each request to a GPIO bank of `NUM_GPIO` pins, a countdown timer, or the storage controller port. Local registers answer in one cycle. Storage accesses are held in a registered wait state with a timeout. Every accepted request gets exactly one response, either valid or error.

---
 rtl/mmio_router_if.sv | 25 ++
 rtl/mmio_router.sv | 204 ++++++++++++++++++++
 tb/tb_mmio_router.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_router_if.sv
// Core data-port bus between the CPU load/store unit and mmio_router.
// Signal names are as seen from the router side.
interface mmio_router_if #(
  parameter int unsigned MEM_W = 32
) ();
  logic               req_i;
  logic               gnt_o;
  logic [31:0]        addr_i;
  logic               we_i;
  logic [MEM_W/8-1:0] be_i;
  logic [MEM_W-1:0]   wdata_i;
  logic               rvalid_o;
  logic               err_o;
  logic [MEM_W-1:0]   rdata_o;

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, err_o, rdata_o
  );

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i,
    output gnt_o, rvalid_o, err_o, rdata_o
  );
endinterface

// File: rtl/mmio_router.sv
// MMIO router: decodes core requests to GPIO, a countdown timer or the storage port.
// Local registers answer in one cycle; storage accesses wait with a timeout.
module mmio_router #(
  parameter int unsigned MEM_W        = 32,
  parameter int unsigned NUM_GPIO     = 10,
  parameter int unsigned TIMER_W      = 32,
  parameter logic [31:0] IO_BASE      = 32'h0000_0100,
  parameter logic [31:0] SCRATCH_BASE = 32'h0000_1000,
  parameter logic [31:0] EXT_BASE     = 32'h0000_2000,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic                clk,
  input  logic                rst,
  mmio_router_if.slave        bus,
  output logic                st_req_o,
  output logic                st_we_o,
  output logic [31:0]         st_addr_o,
  output logic [MEM_W/8-1:0]  st_be_o,
  output logic [MEM_W-1:0]    st_wdata_o,
  input  logic                st_valid_i,
  input  logic [MEM_W-1:0]    st_rdata_i,
  output logic [NUM_GPIO-1:0] gpio_oe_o,
  output logic [NUM_GPIO-1:0] gpio_out_o,
  input  logic [NUM_GPIO-1:0] gpio_in_i,
  output logic                timer_irq_o
);

  localparam int unsigned BeW  = MEM_W / 8;
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e               r_state, w_state_d;
  logic                 r_rvalid, w_rvalid_d;
  logic                 r_err, w_err_d;
  logic [MEM_W-1:0]     r_rdata, w_rdata_d;
  logic                 r_st_req, w_st_req_d;
  logic                 r_st_we, w_st_we_d;
  logic [31:0]          r_st_addr, w_st_addr_d;
  logic [BeW-1:0]       r_st_be, w_st_be_d;
  logic [MEM_W-1:0]     r_st_wdata, w_st_wdata_d;
  logic [CntW-1:0]      r_wcnt, w_wcnt_d;
  logic [NUM_GPIO-1:0]  r_oe, w_oe_d;
  logic [NUM_GPIO-1:0]  r_out, w_out_d;
  logic [NUM_GPIO-1:0]  r_sync1, r_sync2;
  logic [TIMER_W-1:0]   r_count, w_count_d;
  logic                 r_irq, w_irq_d;

  logic                 w_gnt;
  logic [31:0]          w_off;
  logic                 w_is_store, w_in_io, w_is_dir, w_is_val, w_is_tmr;

  assign w_off      = bus.addr_i - IO_BASE;
  assign w_is_store = bus.addr_i >= SCRATCH_BASE;
  assign w_in_io    = !w_is_store && (bus.addr_i >= IO_BASE);
  assign w_is_dir   = w_in_io && (w_off < 32'(NUM_GPIO));
  assign w_is_val   = w_in_io && (w_off >= 32'(NUM_GPIO)) && (w_off < 32'(2 * NUM_GPIO));
  assign w_is_tmr   = w_in_io && (w_off == 32'(2 * NUM_GPIO));

  always_comb begin
    w_gnt        = 1'b0;
    w_state_d    = r_state;
    w_rvalid_d   = 1'b0;
    w_err_d      = 1'b0;
    w_rdata_d    = '0;
    w_st_req_d   = r_st_req;
    w_st_we_d    = r_st_we;
    w_st_addr_d  = r_st_addr;
    w_st_be_d    = r_st_be;
    w_st_wdata_d = r_st_wdata;
    w_wcnt_d     = r_wcnt;
    w_oe_d       = r_oe;
    w_out_d      = r_out;
    w_count_d    = (r_count != '0) ? r_count - TIMER_W'(1) : r_count;
    w_irq_d      = (r_count == TIMER_W'(1));

    case (r_state)
      StIdle: begin
        w_gnt = bus.req_i;
        if (bus.req_i) begin
          if (w_is_store) begin
            if (bus.we_i && (bus.addr_i >= EXT_BASE)) begin
              w_err_d = 1'b1;
            end else begin
              w_st_req_d   = 1'b1;
              w_st_we_d    = bus.we_i;
              w_st_addr_d  = bus.addr_i;
              w_st_be_d    = bus.be_i;
              w_st_wdata_d = bus.wdata_i;
              w_wcnt_d     = CntW'(1);
              w_state_d    = StWait;
            end
          end else if (w_is_dir) begin
            w_rvalid_d = 1'b1;
            for (int unsigned i = 0; i < NUM_GPIO; i++) begin
              if (w_off == 32'(i)) begin
                if (bus.we_i && bus.be_i[0]) w_oe_d[i] = bus.wdata_i[0];
                if (!bus.we_i) w_rdata_d[0] = r_oe[i];
              end
            end
          end else if (w_is_val) begin
            w_rvalid_d = 1'b1;
            for (int unsigned i = 0; i < NUM_GPIO; i++) begin
              if (w_off == 32'(NUM_GPIO + i)) begin
                if (!bus.we_i) begin
                  w_rdata_d[0] = r_oe[i] ? r_out[i] : r_sync2[i];
                end else if (bus.be_i[0]) begin
                  // Driving an input pin is refused; the register is left alone.
                  if (r_oe[i]) begin
                    w_out_d[i] = bus.wdata_i[0];
                  end else begin
                    w_rvalid_d = 1'b0;
                    w_err_d    = 1'b1;
                  end
                end
              end
            end
          end else if (w_is_tmr) begin
            if (!bus.we_i) begin
              w_rvalid_d = 1'b1;
              w_rdata_d  = MEM_W'(r_count);
            end else if (&bus.be_i) begin
              w_rvalid_d = 1'b1;
              w_count_d  = bus.wdata_i[TIMER_W-1:0];
              w_irq_d    = 1'b0;
            end else begin
              w_err_d = 1'b1;
            end
          end else begin
            w_err_d = 1'b1;
          end
        end
      end
      StWait: begin
        // A valid in the timeout cycle still completes the access.
        if (st_valid_i) begin
          w_state_d  = StIdle;
          w_st_req_d = 1'b0;
          w_rvalid_d = 1'b1;
          w_rdata_d  = r_st_we ? '0 : st_rdata_i;
        end else if (r_wcnt == CntW'(TIMEOUT)) begin
          w_state_d  = StIdle;
          w_st_req_d = 1'b0;
          w_err_d    = 1'b1;
        end else begin
          w_wcnt_d = r_wcnt + CntW'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_rvalid   <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_st_req   <= 1'b0;
      r_st_we    <= 1'b0;
      r_st_addr  <= '0;
      r_st_be    <= '0;
      r_st_wdata <= '0;
      r_wcnt     <= '0;
      r_oe       <= '0;
      r_out      <= '0;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_count    <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_rvalid   <= w_rvalid_d;
      r_err      <= w_err_d;
      r_rdata    <= w_rdata_d;
      r_st_req   <= w_st_req_d;
      r_st_we    <= w_st_we_d;
      r_st_addr  <= w_st_addr_d;
      r_st_be    <= w_st_be_d;
      r_st_wdata <= w_st_wdata_d;
      r_wcnt     <= w_wcnt_d;
      r_oe       <= w_oe_d;
      r_out      <= w_out_d;
      r_sync1    <= gpio_in_i;
      r_sync2    <= r_sync1;
      r_count    <= w_count_d;
      r_irq      <= w_irq_d;
    end
  end

  assign bus.gnt_o    = w_gnt;
  assign bus.rvalid_o = r_rvalid;
  assign bus.err_o    = r_err;
  assign bus.rdata_o  = r_rdata;
  assign st_req_o     = r_st_req;
  assign st_we_o      = r_st_we;
  assign st_addr_o    = r_st_addr;
  assign st_be_o      = r_st_be;
  assign st_wdata_o   = r_st_wdata;
  assign gpio_oe_o    = r_oe;
  assign gpio_out_o   = r_out;
  assign timer_irq_o  = r_irq;

endmodule

// File: tb/tb_mmio_router.sv
// Scoreboard bench for mmio_router: directed cases plus randomized traffic
// against an abstract model of the register map, timer and storage port.
module tb_mmio_router;
  localparam int unsigned G   = 10;
  localparam int unsigned T   = 8;
  localparam logic [31:0] IO  = 32'h0000_0100;
  localparam logic [31:0] SCR = 32'h0000_1000;
  localparam logic [31:0] EXT = 32'h0000_2000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          st_req, st_we, st_valid, irq;
  logic [31:0]   st_addr, st_wdata, st_rdata;
  logic [3:0]    st_be;
  logic [G-1:0]  gpio_oe, gpio_out, gpio_in;

  mmio_router_if #(.MEM_W(32)) bus ();

  mmio_router #(.TIMEOUT(T)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .st_req_o    (st_req),
    .st_we_o     (st_we),
    .st_addr_o   (st_addr),
    .st_be_o     (st_be),
    .st_wdata_o  (st_wdata),
    .st_valid_i  (st_valid),
    .st_rdata_i  (st_rdata),
    .gpio_oe_o   (gpio_oe),
    .gpio_out_o  (gpio_out),
    .gpio_in_i   (gpio_in),
    .timer_irq_o (irq)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          err;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  // Reference state
  logic [G-1:0] m_oe = '0, m_out = '0, pad = '0;
  bit           t_loaded = 0;
  longint       t_load = 0, t_val = 0;
  longint       irq_q[$];
  bit           chk_en = 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint timer_at(input longint c);
    longint v;
    if (!t_loaded) return 0;
    v = t_val - (c - t_load - 1);
    return (v < 0) ? 0 : v;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    bit   ex;
    if (bus.rvalid_o && bus.err_o) chk("resp_exclusive", 1, 0);
    if (bus.rvalid_o || bus.err_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", {bus.rvalid_o, bus.err_o}, 0);
      end else begin
        e = sb.pop_front();
        chk("resp_cycle", cyc, e.cyc);
        chk("resp_err", bus.err_o, e.err);
        chk("resp_rdata", bus.rdata_o, e.err ? 32'h0 : e.data);
      end
    end else begin
      chk("rdata_idle", bus.rdata_o, 0);
      if (sb.size() != 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        chk("missing_resp_at", cyc, e.cyc);
      end
    end
    if (chk_en) begin
      ex = 0;
      foreach (irq_q[i]) if (irq_q[i] == cyc) ex = 1;
      chk("timer_irq", irq, ex);
      chk("gpio_oe", gpio_oe, m_oe);
      chk("gpio_out", gpio_out, m_out);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Single-cycle transaction (local register, decode error, or rejected write).
  task automatic issue(input logic [31:0] a, input logic we, input logic [3:0] be,
                       input logic [31:0] wd);
    exp_t        e;
    logic [31:0] off;
    int          p;
    int          upd_oe = -1, upd_out = -1;
    longint      keep[$];
    bus.req_i = 1; bus.addr_i = a; bus.we_i = we; bus.be_i = be; bus.wdata_i = wd;
    e.err = 0; e.data = 0; e.cyc = cyc + 1;
    off = a - IO;
    if (a >= SCR) begin
      e.err = 1;
    end else if (a >= IO && off < G) begin
      p = int'(off);
      if (we && be[0]) upd_oe = p;
      if (!we) e.data = {31'b0, m_oe[p]};
    end else if (a >= IO && off < 2 * G) begin
      p = int'(off) - G;
      if (!we) e.data = {31'b0, m_oe[p] ? m_out[p] : pad[p]};
      else if (be[0]) begin
        if (m_oe[p]) upd_out = p;
        else e.err = 1;
      end
    end else if (a >= IO && off == 2 * G) begin
      if (!we) e.data = 32'(timer_at(cyc));
      else if (be == 4'hF) begin
        foreach (irq_q[i]) if (irq_q[i] <= cyc) keep.push_back(irq_q[i]);
        irq_q = keep;
        t_loaded = 1; t_load = cyc; t_val = longint'(wd);
        if (wd != 0) irq_q.push_back(cyc + t_val + 1);
      end else e.err = 1;
    end else begin
      e.err = 1;
    end
    sb.push_back(e);
    #1;
    chk("gnt_idle", bus.gnt_o, 1);
    @(posedge clk);
    #1;
    bus.req_i = 0;
    if (upd_oe >= 0) m_oe[upd_oe] = wd[0];
    if (upd_out >= 0) m_out[upd_out] = wd[0];
    chk("st_req_local", st_req, 0);
  endtask

  // Storage access; st_valid is raised lat cycles after acceptance.
  task automatic st_txn(input logic [31:0] a, input logic we, input logic [3:0] be,
                        input logic [31:0] wd, input int lat, input logic [31:0] d);
    exp_t e;
    int   endk;
    endk = (lat <= T) ? lat : T;
    e.err = (lat > T);
    e.data = (we || e.err) ? 32'h0 : d;
    e.cyc = cyc + endk + 1;
    bus.req_i = 1; bus.addr_i = a; bus.we_i = we; bus.be_i = be; bus.wdata_i = wd;
    sb.push_back(e);
    #1;
    chk("gnt_idle", bus.gnt_o, 1);
    for (int k = 1; k <= endk; k++) begin
      @(posedge clk);
      #1;
      bus.req_i = (k < endk);
      bus.addr_i = $urandom; bus.we_i = 1'($urandom); bus.wdata_i = $urandom;
      st_valid = (k == lat);
      st_rdata = (k == lat) ? d : $urandom;
      #1;
      chk("gnt_wait", bus.gnt_o, 0);
      chk("st_req_wait", st_req, 1);
      chk("st_addr", st_addr, a);
      chk("st_we", st_we, we);
      chk("st_be", st_be, be);
      chk("st_wdata", st_wdata, wd);
    end
    for (int k = endk + 1; k <= lat; k++) begin
      @(posedge clk);
      #1;
      bus.req_i = 0;
      st_valid = (k == lat);
      st_rdata = $urandom;
      #1;
      chk("st_req_late", st_req, 0);
    end
    @(posedge clk);
    #1;
    bus.req_i = 0; st_valid = 0;
    chk("st_req_done", st_req, 0);
  endtask

  task automatic set_pad(input logic [G-1:0] v);
    pad = v;
    gpio_in = v;
    idle(3);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_st_req"}, st_req, 0);
    chk({tag, "_st_addr"}, st_addr, 0);
    chk({tag, "_gpio_oe"}, gpio_oe, 0);
    chk({tag, "_gpio_out"}, gpio_out, 0);
    chk({tag, "_irq"}, irq, 0);
    chk({tag, "_rvalid"}, bus.rvalid_o, 0);
    chk({tag, "_err"}, bus.err_o, 0);
    chk({tag, "_rdata"}, bus.rdata_o, 0);
  endtask

  task automatic reset_mid_wait();
    bus.req_i = 1; bus.addr_i = SCR + 32'h40; bus.we_i = 0; bus.be_i = 4'hF;
    @(posedge clk);
    #1;
    bus.req_i = 0;
    #1;
    chk("rst_pre_st_req", st_req, 1);
    @(posedge clk);
    #1;
    chk_en = 0;
    rst = 0;
    @(posedge clk);
    #1;
    check_all_zero("rst_wait");
    rst = 1;
    m_oe = '0; m_out = '0; t_loaded = 0; t_val = 0; irq_q.delete();
    idle(1);
    chk_en = 1;
    idle(T + 3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          r;
    logic [31:0] a;
    logic        we;
    bus.req_i = 0; bus.addr_i = 0; bus.we_i = 0; bus.be_i = 0; bus.wdata_i = 0;
    st_valid = 0; st_rdata = 0; gpio_in = 0;

    idle(2);
    check_all_zero("reset");
    chk("reset_gnt", bus.gnt_o, 0);
    rst = 1;
    idle(1);

    // GPIO
    issue(IO + 3, 1, 4'hF, 1);
    issue(IO + G + 3, 1, 4'hF, 1);
    issue(IO + G + 4, 1, 4'hF, 1);
    issue(IO + G + 3, 1, 4'hE, 0);
    issue(IO + 3, 0, 4'hF, 0);
    set_pad(10'h010);
    issue(IO + G + 4, 0, 4'hF, 0);
    issue(IO + G + 3, 0, 4'hF, 0);

    // Timer: expiry, mid-count read, reload at count 1, bad byte enables
    issue(IO + 2 * G, 1, 4'hF, 5);
    issue(IO + 2 * G, 0, 4'hF, 0);
    issue(IO + 2 * G, 0, 4'hF, 0);
    idle(8);
    issue(IO + 2 * G, 1, 4'hF, 5);
    idle(4);
    issue(IO + 2 * G, 1, 4'hF, 9);
    issue(IO + 2 * G, 1, 4'h7, 3);
    idle(12);

    // Storage, rejected write, decode errors, timeout and valid-at-timeout
    st_txn(SCR, 0, 4'hF, 0, 4, 32'hDEAD_BEEF);
    st_txn(SCR + 4, 1, 4'h3, 32'h1234_5678, 1, 32'hFFFF_FFFF);
    issue(EXT + 4, 1, 4'hF, 32'h55);
    issue(32'h0000_0800, 0, 4'hF, 0);
    issue(IO + 2 * G + 1, 0, 4'hF, 0);
    issue(IO - 1, 1, 4'hF, 0);
    st_txn(EXT + 8, 0, 4'hF, 0, 2, 32'hCAFE_F00D);
    st_txn(SCR, 0, 4'hF, 0, T + 1, 32'h1111_1111);
    st_txn(SCR, 0, 4'hF, 0, T, 32'h2222_2222);

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1: issue(IO + $urandom_range(0, G - 1), 1'($urandom), 4'($urandom), $urandom);
        2, 3: issue(IO + G + $urandom_range(0, G - 1), 1'($urandom), 4'($urandom), $urandom);
        4: issue(IO + 2 * G, 1'($urandom),
                 ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
                 ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 30));
        5: begin
          case ($urandom_range(0, 3))
            0: a = IO + 2 * G + 1;
            1: a = $urandom_range(0, IO - 1);
            2: a = $urandom_range(IO + 2 * G + 1, SCR - 1);
            default: a = $urandom_range(EXT, 32'h0000_3FFF);
          endcase
          issue(a, (a >= EXT) ? 1'b1 : 1'($urandom), 4'($urandom), $urandom);
        end
        6, 7: begin
          a = $urandom_range(SCR, 32'h0000_3FFF) & 32'hFFFF_FFFC;
          we = 1'($urandom);
          if (we && a >= EXT) issue(a, we, 4'($urandom), $urandom);
          else st_txn(a, we, 4'($urandom), $urandom, $urandom_range(1, T + 2), $urandom);
        end
        8: set_pad(G'($urandom));
        default: idle($urandom_range(0, 3));
      endcase
    end

    issue(IO + 0, 1, 4'hF, 1);
    issue(IO + G, 1, 4'hF, 1);
    issue(IO + 2 * G, 1, 4'hF, 50);
    reset_mid_wait();
    issue(IO + 2 * G, 0, 4'hF, 0);
    issue(IO + 0, 0, 4'hF, 0);

    idle(5);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
